// File: rtl/morse_char_assembler_pkg.sv
// Shared definitions for the Morse character assembler: symbol codes,
// accumulator limit, ASCII constants and the lookup-key helper.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_GAP  = 2'b00,
    SYM_DOT  = 2'b01,
    SYM_DASH = 2'b10,
    SYM_STOP = 2'b11
  } sym_t;

  localparam int unsigned MAX_SYM = 5;

  typedef logic [7:0] ascii_t;

  localparam ascii_t ASCII_SPACE = 8'h20;
  localparam ascii_t ASCII_QMARK = 8'h3F;

  // Length sits above the pattern so equal bit patterns of different lengths stay distinct.
  function automatic logic [7:0] lut_key(input logic [2:0] len, input logic [4:0] pattern);
    return {len, pattern};
  endfunction

endpackage

// File: rtl/morse_char_assembler_if.sv
// Symbol input and character output handshake of the Morse character assembler.
// master is the assembler side, slave is the classifier/display side.
interface morse_char_assembler_if;
  import morse_pkg::*;

  sym_t       sym_type;
  logic       char_ready;
  logic       char_valid;
  ascii_t     char_out;
  logic       char_err;
  logic       overrun;
  logic [2:0] sym_count;

  modport master (
    input  sym_type,
    input  char_ready,
    output char_valid,
    output char_out,
    output char_err,
    output overrun,
    output sym_count
  );

  modport slave (
    output sym_type,
    output char_ready,
    input  char_valid,
    input  char_out,
    input  char_err,
    input  overrun,
    input  sym_count
  );

endinterface

// File: rtl/morse_char_assembler_lut.sv
// Combinational Morse decoder: {length, pattern} to ASCII for A-Z and 0-9.
// Patterns are right-aligned with the first symbol in the highest used bit, DASH = 1.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [4:0] pattern,
  output logic       hit,
  output ascii_t     ascii
);

  always_comb begin
    hit   = 1'b1;
    ascii = ASCII_QMARK;
    case (lut_key(len, pattern))
      8'b001_00000: ascii = "E";
      8'b001_00001: ascii = "T";
      8'b010_00000: ascii = "I";
      8'b010_00001: ascii = "A";
      8'b010_00010: ascii = "N";
      8'b010_00011: ascii = "M";
      8'b011_00000: ascii = "S";
      8'b011_00001: ascii = "U";
      8'b011_00010: ascii = "R";
      8'b011_00011: ascii = "W";
      8'b011_00100: ascii = "D";
      8'b011_00101: ascii = "K";
      8'b011_00110: ascii = "G";
      8'b011_00111: ascii = "O";
      8'b100_00000: ascii = "H";
      8'b100_00001: ascii = "V";
      8'b100_00010: ascii = "F";
      8'b100_00100: ascii = "L";
      8'b100_00110: ascii = "P";
      8'b100_00111: ascii = "J";
      8'b100_01000: ascii = "B";
      8'b100_01001: ascii = "X";
      8'b100_01010: ascii = "C";
      8'b100_01011: ascii = "Y";
      8'b100_01100: ascii = "Z";
      8'b100_01101: ascii = "Q";
      8'b101_01111: ascii = "1";
      8'b101_00111: ascii = "2";
      8'b101_00011: ascii = "3";
      8'b101_00001: ascii = "4";
      8'b101_00000: ascii = "5";
      8'b101_10000: ascii = "6";
      8'b101_11000: ascii = "7";
      8'b101_11100: ascii = "8";
      8'b101_11110: ascii = "9";
      8'b101_11111: ascii = "0";
      default: begin
        hit   = 1'b0;
        ascii = ASCII_QMARK;
      end
    endcase
  end

endmodule

// File: rtl/morse_char_assembler.sv
// Assembles classified Morse symbols into ASCII characters and offers them
// downstream over a valid/ready handshake, flagging overflow and dropped letters.
module morse_char_assembler
  import morse_pkg::*;
(
  input  logic clk_board,
  input  logic clear,
  morse_char_assembler_if.master bus
);

  sym_t       type_q;
  logic [4:0] pattern;
  logic [2:0] sym_count_q;
  logic       ovf;
  logic       char_valid_q;
  ascii_t     char_out_q;
  logic       char_err_q;
  logic       overrun_q;

  logic       sym_event;
  logic       gap_event;
  logic       mark_event;
  logic       is_dash;
  logic       transfer;
  logic       pending;
  logic       load;
  logic       lut_hit;
  ascii_t     lut_ascii;
  ascii_t     dec_char;
  logic       dec_err;

  // A held symbol code produces a single event on its first cycle only.
  assign sym_event  = (bus.sym_type != type_q) && (bus.sym_type != SYM_STOP);
  assign gap_event  = sym_event && (bus.sym_type == SYM_GAP);
  assign mark_event = sym_event && (bus.sym_type != SYM_GAP);
  assign is_dash    = (bus.sym_type == SYM_DASH);

  // A character being handed over this cycle frees the slot for a same-cycle GAP.
  assign transfer = char_valid_q && bus.char_ready;
  assign pending  = char_valid_q && !transfer;
  assign load     = gap_event && !pending;

  morse_lut u_lut (
    .len     (sym_count_q),
    .pattern (pattern),
    .hit     (lut_hit),
    .ascii   (lut_ascii)
  );

  always_comb begin
    dec_char = ASCII_QMARK;
    dec_err  = 1'b1;
    if (sym_count_q == 3'd0) begin
      dec_char = ASCII_SPACE;
      dec_err  = 1'b0;
    end else if (!ovf && lut_hit) begin
      dec_char = lut_ascii;
      dec_err  = 1'b0;
    end
  end

  always_ff @(posedge clk_board or negedge clear) begin
    if (!clear) begin
      type_q <= SYM_STOP;
    end else begin
      type_q <= bus.sym_type;
    end
  end

  // Symbol accumulator; a GAP always empties it, even when its letter is dropped.
  always_ff @(posedge clk_board or negedge clear) begin
    if (!clear) begin
      pattern     <= 5'd0;
      sym_count_q <= 3'd0;
      ovf         <= 1'b0;
    end else if (gap_event) begin
      pattern     <= 5'd0;
      sym_count_q <= 3'd0;
      ovf         <= 1'b0;
    end else if (mark_event) begin
      if (sym_count_q < 3'(MAX_SYM)) begin
        pattern     <= {pattern[3:0], is_dash};
        sym_count_q <= sym_count_q + 3'd1;
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_board or negedge clear) begin
    if (!clear) begin
      char_valid_q <= 1'b0;
      char_out_q   <= 8'h00;
      char_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (load) begin
        char_valid_q <= 1'b1;
        char_out_q   <= dec_char;
        char_err_q   <= dec_err;
      end else if (transfer) begin
        char_valid_q <= 1'b0;
      end
      if (gap_event && pending) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.char_valid = char_valid_q;
  assign bus.char_out   = char_out_q;
  assign bus.char_err   = char_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.sym_count  = sym_count_q;

endmodule
